// File: rtl/comparador_serie.sv
// Bit-serial unsigned comparator: walks an operand pair one bit per clock
// and reports eq/gt/lt over valid/ready handshakes.
module comparador_serie #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             eq,
   output logic             gt,
   output logic             lt,
   output logic             busy
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHIFT,
      S_DONE
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic [WIDTH-1:0] r_sa;
   logic [WIDTH-1:0] r_sb;
   logic [CW-1:0]    r_cnt;
   logic             r_eq_acc;
   logic             r_gt_acc;
   logic             r_lt_acc;
   logic             r_decided;
   logic             r_vld;
   logic             r_eq;
   logic             r_gt;
   logic             r_lt;
   logic             w_ab;
   logic             w_bb;
   logic             w_bit_eq;

   assign w_ab     = MSB_FIRST ? r_sa[WIDTH-1] : r_sa[0];
   assign w_bb     = MSB_FIRST ? r_sb[WIDTH-1] : r_sb[0];
   assign w_bit_eq = (~w_ab & ~w_bb) | (w_ab & w_bb);

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE:  if (in_valid) w_next = S_SHIFT;
         S_SHIFT: if (r_cnt == '0) w_next = S_DONE;
         S_DONE:  if (r_vld && out_ready) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_sa      <= '0;
         r_sb      <= '0;
         r_cnt     <= '0;
         r_eq_acc  <= 1'b0;
         r_gt_acc  <= 1'b0;
         r_lt_acc  <= 1'b0;
         r_decided <= 1'b0;
         r_vld     <= 1'b0;
         r_eq      <= 1'b0;
         r_gt      <= 1'b0;
         r_lt      <= 1'b0;
      end else begin
         r_state <= w_next;
         unique case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_sa      <= a;
                  r_sb      <= b;
                  r_cnt     <= CW'(WIDTH - 1);
                  r_eq_acc  <= 1'b1;
                  r_gt_acc  <= 1'b0;
                  r_lt_acc  <= 1'b0;
                  r_decided <= 1'b0;
               end
            end
            S_SHIFT: begin
               if (MSB_FIRST) begin
                  r_sa <= r_sa << 1;
                  r_sb <= r_sb << 1;
               end else begin
                  r_sa <= r_sa >> 1;
                  r_sb <= r_sb >> 1;
               end
               r_eq_acc <= r_eq_acc & w_bit_eq;
               // MSB-first keeps the first difference; LSB-first keeps the last.
               if (!w_bit_eq && (!MSB_FIRST || !r_decided)) begin
                  r_gt_acc  <= w_ab;
                  r_lt_acc  <= w_bb;
                  r_decided <= 1'b1;
               end
               if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
            end
            S_DONE: begin
               if (!r_vld) begin
                  r_vld <= 1'b1;
                  r_eq  <= r_eq_acc;
                  r_gt  <= r_gt_acc;
                  r_lt  <= r_lt_acc;
               end else if (out_ready) begin
                  r_vld <= 1'b0;
                  r_eq  <= 1'b0;
                  r_gt  <= 1'b0;
                  r_lt  <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign in_ready  = (r_state == S_IDLE);
   assign busy      = (r_state != S_IDLE);
   assign out_valid = r_vld;
   assign eq        = r_eq;
   assign gt        = r_gt;
   assign lt        = r_lt;

endmodule

// File: tb/tb_comparador_serie.sv
// Bench for comparador_serie: one MSB-first and one LSB-first instance
// checked against plain ==, >, < on the operand values.
module tb_comparador_serie;

   localparam int W = 8;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic         m_iv, m_ir, m_ov, m_or, m_eq, m_gt, m_lt, m_busy;
   logic [W-1:0] m_a, m_b;
   logic         l_iv, l_ir, l_ov, l_or, l_eq, l_gt, l_lt, l_busy;
   logic [W-1:0] l_a, l_b;

   int n_cmp = 0;
   int n_bad = 0;

   comparador_serie #(.WIDTH(W), .MSB_FIRST(1'b1)) u_m (
      .clk(clk), .rst_n(rst_n),
      .in_valid(m_iv), .in_ready(m_ir), .a(m_a), .b(m_b),
      .out_valid(m_ov), .out_ready(m_or),
      .eq(m_eq), .gt(m_gt), .lt(m_lt), .busy(m_busy)
   );

   comparador_serie #(.WIDTH(W), .MSB_FIRST(1'b0)) u_l (
      .clk(clk), .rst_n(rst_n),
      .in_valid(l_iv), .in_ready(l_ir), .a(l_a), .b(l_b),
      .out_valid(l_ov), .out_ready(l_or),
      .eq(l_eq), .gt(l_gt), .lt(l_lt), .busy(l_busy)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // {in_ready, out_valid, busy, eq, gt, lt}
   function automatic logic [5:0] view(bit lsb);
      if (lsb) return {l_ir, l_ov, l_busy, l_eq, l_gt, l_lt};
      return {m_ir, m_ov, m_busy, m_eq, m_gt, m_lt};
   endfunction

   function automatic logic [5:0] expect_done(logic [W-1:0] x, logic [W-1:0] y);
      return {1'b0, 1'b1, 1'b1, x == y, x > y, x < y};
   endfunction

   task automatic set_in(bit lsb, logic v, logic [W-1:0] x, logic [W-1:0] y);
      if (lsb) begin
         l_iv = v; l_a = x; l_b = y;
      end else begin
         m_iv = v; m_a = x; m_b = y;
      end
   endtask

   task automatic set_or(bit lsb, logic r);
      if (lsb) l_or = r;
      else m_or = r;
   endtask

   task automatic start(bit lsb, logic [W-1:0] x, logic [W-1:0] y);
      set_in(lsb, 1'b1, x, y);
      tick();
      set_in(lsb, 1'b0, W'($urandom), W'($urandom));
   endtask

   task automatic wait_valid(bit lsb, string nm, output int lat);
      logic [5:0] v;
      lat = 0;
      v = view(lsb);
      while (v[4] !== 1'b1 && lat < 40) begin
         tick();
         lat++;
         v = view(lsb);
      end
      if (lat >= 40) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s timeout: no out_valid within %0d cycles", nm, lat);
      end
   endtask

   task automatic compare_pair(bit lsb, logic [W-1:0] x, logic [W-1:0] y,
                               string nm, bit chk_lat);
      int lat;
      logic [5:0] v;
      logic [5:0] e;
      set_or(lsb, 1'b1);
      start(lsb, x, y);
      wait_valid(lsb, nm, lat);
      e = expect_done(x, y);
      v = view(lsb);
      n_cmp++;
      if (v !== e) begin
         n_bad++;
         $display("FAIL %s result a=%h b=%h: got %b want %b", nm, x, y, v, e);
      end
      if (chk_lat) begin
         n_cmp++;
         if (lat !== W + 1) begin
            n_bad++;
            $display("FAIL %s latency: got %0d want %0d", nm, lat, W + 1);
         end
      end
      tick();
      v = view(lsb);
      n_cmp++;
      if (v !== 6'b100000) begin
         n_bad++;
         $display("FAIL %s idle after handshake: got %b want 100000", nm, v);
      end
   endtask

   task automatic test_reset();
      logic [5:0] v;
      rst_n = 1'b0;
      set_in(0, 1'b0, '0, '0);
      set_in(1, 1'b0, '0, '0);
      set_or(0, 1'b0);
      set_or(1, 1'b0);
      tick();
      tick();
      for (int s = 0; s < 2; s++) begin
         v = view(s[0]);
         n_cmp++;
         if (v !== 6'b100000) begin
            n_bad++;
            $display("FAIL reset_state inst%0d: got %b want 100000", s, v);
         end
      end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_equal();
      compare_pair(0, 8'hA5, 8'hA5, "equal_a5", 1'b1);
   endtask

   task automatic test_gt_lt();
      compare_pair(0, 8'h80, 8'h7F, "gt_80_7f", 1'b1);
      compare_pair(0, 8'h00, 8'h01, "lt_00_01", 1'b1);
   endtask

   task automatic test_backpressure();
      int lat;
      logic [5:0] v;
      set_or(0, 1'b0);
      start(0, 8'h3C, 8'h3D);
      wait_valid(0, "bp", lat);
      for (int i = 0; i < 5; i++) begin
         v = view(0);
         n_cmp++;
         if (v !== 6'b011001) begin
            n_bad++;
            $display("FAIL bp_hold cycle%0d: got %b want 011001", i, v);
         end
         tick();
      end
      set_or(0, 1'b1);
      tick();
      v = view(0);
      n_cmp++;
      if (v !== 6'b100000) begin
         n_bad++;
         $display("FAIL bp_release: got %b want 100000", v);
      end
   endtask

   task automatic test_ignore_busy();
      int lat;
      logic [5:0] v;
      set_or(0, 1'b1);
      start(0, 8'h01, 8'h02);
      tick();
      tick();
      set_in(0, 1'b1, 8'hFF, 8'h00);
      tick();
      set_in(0, 1'b0, 8'h00, 8'h00);
      wait_valid(0, "busy_ign", lat);
      v = view(0);
      n_cmp++;
      if (v !== 6'b011001) begin
         n_bad++;
         $display("FAIL busy_ign result: got %b want 011001", v);
      end
      tick();
      v = view(0);
      n_cmp++;
      if (v !== 6'b100000) begin
         n_bad++;
         $display("FAIL busy_ign idle: got %b want 100000", v);
      end
      compare_pair(0, 8'hFF, 8'h00, "busy_next_gt", 1'b1);
   endtask

   task automatic test_reset_mid();
      logic [5:0] v;
      bit seen;
      set_or(0, 1'b1);
      start(0, 8'h12, 8'h34);
      tick();
      tick();
      tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      v = view(0);
      n_cmp++;
      if (v !== 6'b100000) begin
         n_bad++;
         $display("FAIL rst_mid state: got %b want 100000", v);
      end
      seen = 1'b0;
      for (int i = 0; i < 15; i++) begin
         tick();
         if (m_ov !== 1'b0) seen = 1'b1;
      end
      n_cmp++;
      if (seen !== 1'b0) begin
         n_bad++;
         $display("FAIL rst_mid stale: got out_valid=1 want 0");
      end
   endtask

   task automatic test_random(bit lsb, int n, string nm);
      logic [W-1:0] x, y;
      for (int i = 0; i < n; i++) begin
         x = W'($urandom);
         y = W'($urandom);
         unique case (i % 8)
            0: y = x;
            1: begin x = 8'h00; y = 8'hFF; end
            2: begin x = 8'hFF; y = 8'h00; end
            3: y = x ^ 8'h01;
            4: y = x ^ 8'h80;
            default: ;
         endcase
         compare_pair(lsb, x, y, nm, (i % 50) == 0);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      test_reset();
      test_equal();
      test_gt_lt();
      test_backpressure();
      test_ignore_busy();
      test_reset_mid();
      test_random(1'b1, 1000, "rand_lsb");
      test_random(1'b0, 200, "rand_msb");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
